// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - parametrised data memory with byte-enable stores, 1-cycle loads and sequential clear
// Optional: define DMEM_PRELOAD_EN to write PRELOAD_VALUE at PRELOAD_ADDR during initialisation.
module data_mem_ctrl #(
    parameter int                DATA_W        = 32,
    parameter int                DEPTH         = 16,
    parameter int                ADDR_W        = 4,
    parameter int                PRELOAD_ADDR  = 2,
    parameter logic [DATA_W-1:0] PRELOAD_VALUE = 32'hDEADBAEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                err,
    output logic                init_done
);

    localparam int                BE_W     = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] init_word;
    logic              accept;
    logic              in_range;

    // clr blocks acceptance in the same cycle so a racing store cannot survive the clear
    assign req_ready = init_done & ~clr;
    assign accept    = req_valid & req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_V;

`ifdef DMEM_PRELOAD_EN
    assign init_word = (int'(ptr) == PRELOAD_ADDR) ? PRELOAD_VALUE : '0;
`else
    assign init_word = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            ptr       <= '0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= accept & ~req_we;
            err       <= accept & ~in_range;
            if (accept && !req_we) begin
                rsp_rdata <= in_range ? mem[req_addr] : '0;
            end
            if (clr) begin
                state     <= INIT;
                ptr       <= '0;
                init_done <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        if (ptr == PTR_LAST) begin
                            state     <= IDLE;
                            ptr       <= '0;
                            init_done <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ptr never exceeds DEPTH-1, so the clear write is always in range
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[ptr] <= init_word;
        end else if (accept && req_we && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed bench driving a DEPTH=16 and a DEPTH=12 instance with shared stimulus
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rdy16, rv16, err16, id16;
    logic [31:0] rd16;
    logic        rdy12, rv12, err12, id12;
    logic [31:0] rd12;

    int checks = 0;
    int errors = 0;

    logic [31:0] m16 [16];
    logic [31:0] m12 [12];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(16)) dut16 (
        .clk(clk), .reset(reset), .clr(clr), .req_valid(req_valid), .req_ready(rdy16),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv16), .rsp_rdata(rd16), .err(err16), .init_done(id16)
    );

    data_mem_ctrl #(.DEPTH(12)) dut12 (
        .clk(clk), .reset(reset), .clr(clr), .req_valid(req_valid), .req_ready(rdy12),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv12), .rsp_rdata(rd12), .err(err12), .init_done(id12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] init_word(input int a);
`ifdef DMEM_PRELOAD_EN
        return (a == 2) ? 32'hDEADBAEF : 32'h0;
`else
        return (a < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    task automatic model_init();
        for (int i = 0; i < 16; i++) m16[i] = init_word(i);
        for (int i = 0; i < 12; i++) m12[i] = init_word(i);
    endtask

    task automatic model_store(input int a, input logic [31:0] d, input logic [3:0] be);
        for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
                m16[a][8*l +: 8] = d[8*l +: 8];
                if (a < 12) m12[a][8*l +: 8] = d[8*l +: 8];
            end
        end
    endtask

    task automatic check_load_rsp(input string tag, input int a);
        check({tag, "_rv16"}, {31'b0, rv16}, 32'd1);
        check({tag, "_rd16"}, rd16, m16[a]);
        check({tag, "_err16"}, {31'b0, err16}, 32'd0);
        check({tag, "_rv12"}, {31'b0, rv12}, 32'd1);
        check({tag, "_rd12"}, rd12, (a < 12) ? m12[a] : 32'h0);
        check({tag, "_err12"}, {31'b0, err12}, (a >= 12) ? 32'd1 : 32'd0);
    endtask

    task automatic store(input int a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'(a); req_wdata = d; req_be = be;
        cycle();
        check($sformatf("st%0d_rv16", a), {31'b0, rv16}, 32'd0);
        check($sformatf("st%0d_err12", a), {31'b0, err12}, (a >= 12) ? 32'd1 : 32'd0);
        model_store(a, d, be);
        req_valid = 1'b0;
    endtask

    task automatic load(input int a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(a);
        cycle();
        check_load_rsp($sformatf("ld%0d", a), a);
        req_valid = 1'b0;
    endtask

    task automatic load_stream(input string tag);
        int p16 = 0;
        int p12 = 0;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(i);
            cycle();
            if (rv16) p16++;
            if (rv12) p12++;
            check($sformatf("%s_rd16_%0d", tag, i), rd16, m16[i]);
            check($sformatf("%s_rd12_%0d", tag, i), rd12, (i < 12) ? m12[i] : 32'h0);
            check($sformatf("%s_err12_%0d", tag, i), {31'b0, err12}, (i >= 12) ? 32'd1 : 32'd0);
        end
        req_valid = 1'b0;
        check({tag, "_pulses16"}, 32'(p16), 32'd16);
        check({tag, "_pulses12"}, 32'(p12), 32'd16);
    endtask

    task automatic wait_ready(input string tag);
        int f16 = 0;
        int f12 = 0;
        check({tag, "_rdy16_low"}, {31'b0, rdy16}, 32'd0);
        check({tag, "_rdy12_low"}, {31'b0, rdy12}, 32'd0);
        for (int n = 1; n <= 40; n++) begin
            cycle();
            if (rdy16 && f16 == 0) f16 = n;
            if (rdy12 && f12 == 0) f12 = n;
            if (f16 != 0 && f12 != 0) break;
        end
        check({tag, "_init16"}, 32'(f16), 32'd16);
        check({tag, "_init12"}, 32'(f12), 32'd12);
        check({tag, "_done16"}, {31'b0, id16}, 32'd1);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cycle();
        cycle();
        check("rst_ready", {31'b0, rdy16}, 32'd0);
        check("rst_rv", {31'b0, rv16}, 32'd0);
        check("rst_rd", rd16, 32'h0);
        check("rst_err", {31'b0, err16}, 32'd0);
        check("rst_done", {31'b0, id16}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 4'h0; req_wdata = 32'h0; req_be = 4'h0;

        reset_dut();
        wait_ready("por");
        model_init();
        load_stream("clean");

        store(5, 32'h11223344, 4'hF);
        store(5, 32'hAABBCCDD, 4'b0101);
        load(5);
        check("be_merge16", rd16, 32'h11BB33DD);
        check("be_merge12", rd12, 32'h11BB33DD);

        store(3, 32'h0000CAFE, 4'hF);
        load(3);
        check("b2b_cafe", rd16, 32'h0000CAFE);

        store(6, 32'hFFFFFFFF, 4'h0);
        load(6);

        load(13);
        store(14, 32'h12345678, 4'hF);
        load_stream("oor");

        clr = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7;
        req_wdata = 32'h77777777; req_be = 4'hF;
        #1;
        check("clr_block16", {31'b0, rdy16}, 32'd0);
        check("clr_block12", {31'b0, rdy12}, 32'd0);
        cycle();
        clr = 1'b0; req_valid = 1'b0;
        wait_ready("clr");
        model_init();
        load_stream("postclr");

        store(9, 32'h99999999, 4'hF);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
        cycle();
        req_valid = 1'b0;
        check("pend_rv", {31'b0, rv16}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_rv16", {31'b0, rv16}, 32'd0);
        check("arst_rv12", {31'b0, rv12}, 32'd0);
        check("arst_rd", rd16, 32'h0);
        check("arst_ready", {31'b0, rdy16}, 32'd0);
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 7; k++) cycle();
        reset = 1'b1;
        #1;
        check("midinit_done", {31'b0, id16}, 32'd0);
        cycle();
        reset = 1'b0;
        wait_ready("midinit");
        model_init();
        load_stream("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
